arbl2dr_n: RTL and testbench
============================

Name: arbl2dr_n

Overview:
- Parametrised successor of the two/four-pipe L2-to-directory aggregator.
- Merges NPORTS L2 slices into one directory interface.
- Upstream (L2 to DR) req, disp and snoop_ack channels: round-robin arbitration into registered output slots.
- Downstream (DR to L2) snack: unicast to one port, or broadcast to all ports with per-port delivery tracking. Downstream dack: routed to one port by ID.

Parameters:
- NPORTS, 4, number of L2 slices; power of 2, range 2..16.
- PID_W, $clog2(NPORTS), port-ID field width.
- REQ_W, 64, req payload width.
- DISP_W, 600, disp payload width.
- SACK_W, 16, snoop_ack payload width.
- SNACK_W, 600, snack payload width.
- DACK_W, 16, dack payload width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- l2todr_req_valid / l2todr_req_retry / l2todr_req  in / out / in  NPORTS / NPORTS / NPORTS*REQ_W  per-port requests; port i in slice [i*REQ_W +: REQ_W]
- l2todr_disp_valid / _retry / l2todr_disp  in / out / in  NPORTS / NPORTS / NPORTS*DISP_W  per-port displacements
- l2todr_snoop_ack_valid / _retry / l2todr_snoop_ack  in / out / in  NPORTS / NPORTS / NPORTS*SACK_W  per-port snoop acks
- drtol2_snack_valid / _retry / drtol2_snack  out / in / out  NPORTS / NPORTS / NPORTS*SNACK_W  per-port snack
- drtol2_dack_valid / _retry / drtol2_dack  out / in / out  NPORTS / NPORTS / NPORTS*DACK_W  per-port dack
- dr_req_valid / dr_req_retry / dr_req  out / in / out  1 / 1 / REQ_W  aggregated request
- dr_disp_valid / _retry / dr_disp  out / in / out  1 / 1 / DISP_W
- dr_snoop_ack_valid / _retry / dr_snoop_ack  out / in / out  1 / 1 / SACK_W
- dr_snack_valid / _retry / dr_snack  in / out / in  1 / 1 / SNACK_W
- dr_dack_valid / _retry / dr_dack  in / out / in  1 / 1 / DACK_W

Behaviour:
- Handshake on every channel: a beat transfers in a cycle where valid=1 and retry=0. The producer holds valid and data stable until the beat transfers.
- Reset: all valid outputs 0. All retry outputs 1 during reset, then 0 when idle. RR pointers = 0. All buffers empty.
- Reset mid-operation: in-flight buffered beats are dropped. Pending broadcast masks are cleared.

Upstream channels (req, disp, snoop_ack), identical and independent:
- Each channel has a 1-entry output slot.
- The slot accepts a new beat when empty, or when it drains in the same cycle (dr_*_retry=0). This gives full throughput.
- Grant goes to the first valid port at or after the RR pointer. The pointer then moves to grant+1 mod NPORTS. The pointer does not move if nothing is granted.
- Granted port: retry=0. All other ports: retry=1.
- req only: the arbiter overwrites bits [PID_W-1:0] of the payload with the source port index.
- Latency: input to dr_* valid is 1 cycle.

Downstream snack:
- 1-entry buffer plus NPORTS-bit pending mask.
- dr_snack[SNACK_W-1]=1 means broadcast: mask = all ones. Otherwise unicast: mask = onehot(dr_snack[PID_W-1:0]).
- drtol2_snack_valid[i] = buffer valid & mask[i], with identical data on all ports.
- mask[i] clears when port i accepts. The buffer frees when the mask reaches 0.
- dr_snack_retry = buffer valid & ~(the mask clears this cycle). This allows back-to-back beats.
- Ports accept independently; any order and any number per cycle are allowed.

Downstream dack:
- Same 1-entry buffer structure, unicast only, routed by dr_dack[PID_W-1:0].

Boundary cases:
- Simultaneous requests from all ports are served in strict RR order; no port waits more than NPORTS grants.
- A broadcast stalled by one port blocks further snacks, but not dacks.

Decomposition:
- scmem.vh holds the shared payload typedefs (I_l2todr_req_type etc.). The widths above are those typedefs' widths. The snack broadcast-bit and port-ID field positions are defined as constants there.
- Sub-module rr_arb_n: round-robin arbiter, NPORTS request in, one-hot grant plus index out, pointer register. Instantiated three times.
- The downstream buffer is written inline as a generate over two instances.

Test Plan:
- Single port: port 2 sends req with data 0x55, dr_req_retry=0 -> dr_req_valid 1 cycle later, payload bits[1:0]=2, port 2 retry=0.
- Contention: all 4 ports hold req valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one beat per cycle.
- Backpressure: dr_disp_retry=1 for 5 cycles while ports 0 and 3 are valid -> dr_disp stable and no grant advance; after release, port 0 then port 3 delivered.
- Broadcast snack (top bit 1): port 1 retry held for 3 cycles -> ports 0,2,3 accept in cycle 1; port 1 accepts in cycle 4; dr_snack_retry=1 until then, and a second snack is taken the same cycle port 1 accepts.
- Unicast dack to port 3 while a broadcast snack is stalled -> drtol2_dack_valid[3]=1 next cycle; no other dack valid bits set.
- Reset asserted with the req slot full and a snack partially delivered -> next cycle all valids 0 and the RR pointer is back to 0; the first post-reset grant goes to port 0.

Source files
------------

// File: rtl/arbl2dr_n_pkg.sv
// arbl2dr_n_pkg: shared constants for the L2-to-directory aggregator.
// Holds the default channel widths, the snack broadcast-bit position helper
// and the indices of the two downstream buffers.
package arbl2dr_n_pkg;

  localparam int DEF_NPORTS = 4;
  localparam int DEF_REQ_W  = 64;
  localparam int DEF_DISP_W = 600;
  localparam int DEF_SACK_W = 16;
  localparam int DEF_SNACK_W = 600;
  localparam int DEF_DACK_W = 16;

  // Downstream buffer instances (snack shares the structure with dack).
  typedef enum logic [0:0] {
    DS_SNACK = 1'b0,
    DS_DACK  = 1'b1
  } ds_chan_e;

  // The broadcast flag of a snack beat is its most significant bit.
  function automatic int snack_bcast_bit(input int snack_w);
    return snack_w - 1;
  endfunction

endpackage

// File: rtl/arbl2dr_n_rr_arb.sv
// rr_arb_n: round-robin arbiter.
// Ports: clk, reset (sync, active-high), en (a grant may be issued this cycle),
//        req[NPORTS] requests, grant[NPORTS] one-hot grant, idx granted index,
//        any (a grant was issued). The pointer advances to grant+1 only when
//        a grant is issued.
module rr_arb_n
  import arbl2dr_n_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS,
  parameter int PID_W  = $clog2(NPORTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] grant,
  output logic [PID_W-1:0]  idx,
  output logic              any
);

  logic [PID_W-1:0] ptr;

  // First requester at or after the pointer; wraps naturally since NPORTS is a power of 2.
  always_comb begin
    logic [PID_W-1:0] cand;
    cand  = '0;
    grant = '0;
    idx   = ptr;
    any   = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = ptr + PID_W'(k);
      if (en && !any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer register: moves past the winner only on an actual grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= idx + PID_W'(1);
    end
  end

endmodule

// File: rtl/arbl2dr_n.sv
// arbl2dr_n: merges NPORTS L2 slices into one directory interface.
// Upstream req/disp/snoop_ack: per-channel round-robin arbiter feeding a
//   1-entry output slot (accepts when empty or draining, so full throughput).
//   req payload bits [PID_W-1:0] are replaced by the source port index.
// Downstream snack: 1-entry buffer with a per-port pending mask, unicast or
//   broadcast (top payload bit). Downstream dack: same buffer, unicast only.
// Ports: clk, reset (sync, active-high), l2todr_* (NPORTS slices in),
//   drtol2_* (NPORTS slices out), dr_* (single directory side).
module arbl2dr_n
  import arbl2dr_n_pkg::*;
#(
  parameter int NPORTS  = DEF_NPORTS,
  parameter int PID_W   = $clog2(NPORTS),
  parameter int REQ_W   = DEF_REQ_W,
  parameter int DISP_W  = DEF_DISP_W,
  parameter int SACK_W  = DEF_SACK_W,
  parameter int SNACK_W = DEF_SNACK_W,
  parameter int DACK_W  = DEF_DACK_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORTS-1:0]         l2todr_req_valid,
  output logic [NPORTS-1:0]         l2todr_req_retry,
  input  logic [NPORTS*REQ_W-1:0]   l2todr_req,
  input  logic [NPORTS-1:0]         l2todr_disp_valid,
  output logic [NPORTS-1:0]         l2todr_disp_retry,
  input  logic [NPORTS*DISP_W-1:0]  l2todr_disp,
  input  logic [NPORTS-1:0]         l2todr_snoop_ack_valid,
  output logic [NPORTS-1:0]         l2todr_snoop_ack_retry,
  input  logic [NPORTS*SACK_W-1:0]  l2todr_snoop_ack,
  output logic [NPORTS-1:0]         drtol2_snack_valid,
  input  logic [NPORTS-1:0]         drtol2_snack_retry,
  output logic [NPORTS*SNACK_W-1:0] drtol2_snack,
  output logic [NPORTS-1:0]         drtol2_dack_valid,
  input  logic [NPORTS-1:0]         drtol2_dack_retry,
  output logic [NPORTS*DACK_W-1:0]  drtol2_dack,
  output logic                      dr_req_valid,
  input  logic                      dr_req_retry,
  output logic [REQ_W-1:0]          dr_req,
  output logic                      dr_disp_valid,
  input  logic                      dr_disp_retry,
  output logic [DISP_W-1:0]         dr_disp,
  output logic                      dr_snoop_ack_valid,
  input  logic                      dr_snoop_ack_retry,
  output logic [SACK_W-1:0]         dr_snoop_ack,
  input  logic                      dr_snack_valid,
  output logic                      dr_snack_retry,
  input  logic [SNACK_W-1:0]        dr_snack,
  input  logic                      dr_dack_valid,
  output logic                      dr_dack_retry,
  input  logic [DACK_W-1:0]         dr_dack
);

  localparam int SNACK_BCAST = snack_bcast_bit(SNACK_W);

  // ---------------- upstream: req ----------------
  logic [NPORTS-1:0] req_grant;
  logic [PID_W-1:0]  req_idx;
  logic              req_any, req_take;
  logic [REQ_W-1:0]  req_sel;

  assign req_take = ~reset & (~dr_req_valid | ~dr_req_retry);

  rr_arb_n #(.NPORTS(NPORTS), .PID_W(PID_W)) u_req_arb (
    .clk(clk), .reset(reset), .en(req_take), .req(l2todr_req_valid),
    .grant(req_grant), .idx(req_idx), .any(req_any)
  );

  assign l2todr_req_retry = {NPORTS{reset}} | (l2todr_req_valid & ~req_grant);

  // Winner's payload with its port-ID field stamped with the source index.
  always_comb begin
    req_sel            = l2todr_req[req_idx*REQ_W +: REQ_W];
    req_sel[PID_W-1:0] = req_idx;
  end

  // req output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_req_valid <= 1'b0;
    end else if (req_take) begin
      dr_req_valid <= req_any;
      if (req_any) dr_req <= req_sel;
    end
  end

  // ---------------- upstream: disp ----------------
  logic [NPORTS-1:0] disp_grant;
  logic [PID_W-1:0]  disp_idx;
  logic              disp_any, disp_take;

  assign disp_take = ~reset & (~dr_disp_valid | ~dr_disp_retry);

  rr_arb_n #(.NPORTS(NPORTS), .PID_W(PID_W)) u_disp_arb (
    .clk(clk), .reset(reset), .en(disp_take), .req(l2todr_disp_valid),
    .grant(disp_grant), .idx(disp_idx), .any(disp_any)
  );

  assign l2todr_disp_retry = {NPORTS{reset}} | (l2todr_disp_valid & ~disp_grant);

  // disp output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_disp_valid <= 1'b0;
    end else if (disp_take) begin
      dr_disp_valid <= disp_any;
      if (disp_any) dr_disp <= l2todr_disp[disp_idx*DISP_W +: DISP_W];
    end
  end

  // ---------------- upstream: snoop_ack ----------------
  logic [NPORTS-1:0] sack_grant;
  logic [PID_W-1:0]  sack_idx;
  logic              sack_any, sack_take;

  assign sack_take = ~reset & (~dr_snoop_ack_valid | ~dr_snoop_ack_retry);

  rr_arb_n #(.NPORTS(NPORTS), .PID_W(PID_W)) u_sack_arb (
    .clk(clk), .reset(reset), .en(sack_take), .req(l2todr_snoop_ack_valid),
    .grant(sack_grant), .idx(sack_idx), .any(sack_any)
  );

  assign l2todr_snoop_ack_retry = {NPORTS{reset}} | (l2todr_snoop_ack_valid & ~sack_grant);

  // snoop_ack output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_snoop_ack_valid <= 1'b0;
    end else if (sack_take) begin
      dr_snoop_ack_valid <= sack_any;
      if (sack_any) dr_snoop_ack <= l2todr_snoop_ack[sack_idx*SACK_W +: SACK_W];
    end
  end

  // ---------------- downstream: snack / dack buffers ----------------
  logic [1:0]        ds_in_valid, ds_in_retry, ds_load, ds_bcast;
  logic [PID_W-1:0]  ds_pid       [2];
  logic [NPORTS-1:0] ds_port_retry[2];
  logic [NPORTS-1:0] ds_out_valid [2];
  logic [SNACK_W-1:0] snack_data;
  logic [DACK_W-1:0]  dack_data;

  assign ds_in_valid[DS_SNACK]   = dr_snack_valid;
  assign ds_pid[DS_SNACK]        = dr_snack[PID_W-1:0];
  assign ds_bcast[DS_SNACK]      = dr_snack[SNACK_BCAST];
  assign ds_port_retry[DS_SNACK] = drtol2_snack_retry;
  assign ds_in_valid[DS_DACK]    = dr_dack_valid;
  assign ds_pid[DS_DACK]         = dr_dack[PID_W-1:0];
  assign ds_bcast[DS_DACK]       = 1'b0;
  assign ds_port_retry[DS_DACK]  = drtol2_dack_retry;

  for (genvar g = 0; g < 2; g++) begin : g_ds
    logic              buf_valid;
    logic [NPORTS-1:0] mask, remain, new_mask;
    logic              free;

    assign ds_out_valid[g] = {NPORTS{buf_valid}} & mask;
    // Ports still owed the beat after this cycle's acceptances.
    assign remain          = mask & ~(ds_out_valid[g] & ~ds_port_retry[g]);
    // Freeing and refilling in the same cycle keeps back-to-back beats flowing.
    assign free            = ~buf_valid | (remain == '0);
    assign ds_in_retry[g]  = reset | ~free;
    assign ds_load[g]      = ~reset & ds_in_valid[g] & free;
    assign new_mask        = ds_bcast[g] ? {NPORTS{1'b1}} : (NPORTS'(1) << ds_pid[g]);

    // Buffer occupancy and pending-delivery mask.
    always_ff @(posedge clk) begin
      if (reset) begin
        buf_valid <= 1'b0;
        mask      <= '0;
      end else if (ds_load[g]) begin
        buf_valid <= 1'b1;
        mask      <= new_mask;
      end else if (buf_valid) begin
        buf_valid <= |remain;
        mask      <= remain;
      end
    end
  end

  // Buffered snack payload.
  always_ff @(posedge clk) begin
    if (ds_load[DS_SNACK]) snack_data <= dr_snack;
  end

  // Buffered dack payload.
  always_ff @(posedge clk) begin
    if (ds_load[DS_DACK]) dack_data <= dr_dack;
  end

  assign drtol2_snack_valid = ds_out_valid[DS_SNACK];
  assign drtol2_snack       = {NPORTS{snack_data}};
  assign dr_snack_retry     = ds_in_retry[DS_SNACK];
  assign drtol2_dack_valid  = ds_out_valid[DS_DACK];
  assign drtol2_dack        = {NPORTS{dack_data}};
  assign dr_dack_retry      = ds_in_retry[DS_DACK];

endmodule

// File: tb/tb_arbl2dr_n.sv
// tb_arbl2dr_n: directed self-checking bench for arbl2dr_n with 4 ports.
module tb_arbl2dr_n;

  localparam int NP = 4;
  localparam int RW = 64, DW = 600, SW = 16, NW = 600, KW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0]    l2todr_req_valid = '0, l2todr_req_retry;
  logic [NP*RW-1:0] l2todr_req = '0;
  logic [NP-1:0]    l2todr_disp_valid = '0, l2todr_disp_retry;
  logic [NP*DW-1:0] l2todr_disp = '0;
  logic [NP-1:0]    l2todr_snoop_ack_valid = '0, l2todr_snoop_ack_retry;
  logic [NP*SW-1:0] l2todr_snoop_ack = '0;
  logic [NP-1:0]    drtol2_snack_valid, drtol2_snack_retry = '0;
  logic [NP*NW-1:0] drtol2_snack;
  logic [NP-1:0]    drtol2_dack_valid, drtol2_dack_retry = '0;
  logic [NP*KW-1:0] drtol2_dack;
  logic dr_req_valid, dr_req_retry = 1'b0;
  logic [RW-1:0] dr_req;
  logic dr_disp_valid, dr_disp_retry = 1'b0;
  logic [DW-1:0] dr_disp;
  logic dr_snoop_ack_valid, dr_snoop_ack_retry = 1'b0;
  logic [SW-1:0] dr_snoop_ack;
  logic dr_snack_valid = 1'b0, dr_snack_retry;
  logic [NW-1:0] dr_snack = '0;
  logic dr_dack_valid = 1'b0, dr_dack_retry;
  logic [KW-1:0] dr_dack = '0;

  int checks = 0;
  int errors = 0;

  logic [NW-1:0] s1, s2;

  always #5 clk = ~clk;

  arbl2dr_n dut (
    .clk(clk), .reset(reset),
    .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry), .l2todr_req(l2todr_req),
    .l2todr_disp_valid(l2todr_disp_valid), .l2todr_disp_retry(l2todr_disp_retry), .l2todr_disp(l2todr_disp),
    .l2todr_snoop_ack_valid(l2todr_snoop_ack_valid), .l2todr_snoop_ack_retry(l2todr_snoop_ack_retry),
    .l2todr_snoop_ack(l2todr_snoop_ack),
    .drtol2_snack_valid(drtol2_snack_valid), .drtol2_snack_retry(drtol2_snack_retry), .drtol2_snack(drtol2_snack),
    .drtol2_dack_valid(drtol2_dack_valid), .drtol2_dack_retry(drtol2_dack_retry), .drtol2_dack(drtol2_dack),
    .dr_req_valid(dr_req_valid), .dr_req_retry(dr_req_retry), .dr_req(dr_req),
    .dr_disp_valid(dr_disp_valid), .dr_disp_retry(dr_disp_retry), .dr_disp(dr_disp),
    .dr_snoop_ack_valid(dr_snoop_ack_valid), .dr_snoop_ack_retry(dr_snoop_ack_retry), .dr_snoop_ack(dr_snoop_ack),
    .dr_snack_valid(dr_snack_valid), .dr_snack_retry(dr_snack_retry), .dr_snack(dr_snack),
    .dr_dack_valid(dr_dack_valid), .dr_dack_retry(dr_dack_retry), .dr_dack(dr_dack)
  );

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({dr_req_valid, dr_disp_valid, dr_snoop_ack_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_up_valid: got %b expected 000", {dr_req_valid, dr_disp_valid, dr_snoop_ack_valid}); end
    checks++; if ({drtol2_snack_valid, drtol2_dack_valid} !== 8'h00) begin
      errors++; $display("FAIL reset_down_valid: got %h expected 00", {drtol2_snack_valid, drtol2_dack_valid}); end
    checks++; if ({l2todr_req_retry, l2todr_disp_retry, l2todr_snoop_ack_retry} !== 12'hfff) begin
      errors++; $display("FAIL reset_up_retry: got %h expected fff", {l2todr_req_retry, l2todr_disp_retry, l2todr_snoop_ack_retry}); end
    checks++; if ({dr_snack_retry, dr_dack_retry} !== 2'b11) begin
      errors++; $display("FAIL reset_dr_retry: got %b expected 11", {dr_snack_retry, dr_dack_retry}); end
    reset = 1'b0;
    #1;
    checks++; if ({l2todr_req_retry, dr_snack_retry, dr_dack_retry} !== 6'b000000) begin
      errors++; $display("FAIL idle_retry: got %b expected 000000", {l2todr_req_retry, dr_snack_retry, dr_dack_retry}); end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    l2todr_req_valid = 4'b0100;
    l2todr_req[2*RW +: RW] = 64'h55;
    #1;
    checks++; if (l2todr_req_retry !== 4'b0000) begin
      errors++; $display("FAIL single_retry: got %b expected 0000", l2todr_req_retry); end
    @(posedge clk); #1;
    l2todr_req_valid = 4'b0000;
    #1;
    checks++; if (dr_req_valid !== 1'b1 || dr_req !== 64'h56) begin
      errors++; $display("FAIL single_out: got v=%b d=%h expected v=1 d=56", dr_req_valid, dr_req); end
    @(posedge clk); #1;
    checks++; if (dr_req_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got %b expected 0", dr_req_valid); end
  endtask

  task automatic test_contention();
    logic [NP-1:0] exp_r;
    logic [RW-1:0] exp_d;
    do_reset();
    for (int p = 0; p < NP; p++) l2todr_req[p*RW +: RW] = 64'hA0 + 64'h100 * 64'(p);
    l2todr_req_valid = 4'hf;
    for (int k = 0; k < 8; k++) begin
      exp_r = ~(4'b0001 << (k % 4));
      exp_d = 64'hA0 + 64'h100 * 64'(k % 4) + 64'(k % 4);
      #1;
      checks++; if (l2todr_req_retry !== exp_r) begin
        errors++; $display("FAIL contention_retry[%0d]: got %b expected %b", k, l2todr_req_retry, exp_r); end
      @(posedge clk); #1;
      checks++; if (dr_req_valid !== 1'b1 || dr_req !== exp_d) begin
        errors++; $display("FAIL contention_out[%0d]: got v=%b d=%h expected v=1 d=%h", k, dr_req_valid, dr_req, exp_d); end
    end
    l2todr_req_valid = 4'h0;
    @(posedge clk); #1;
    checks++; if (dr_req_valid !== 1'b0) begin
      errors++; $display("FAIL contention_drain: got %b expected 0", dr_req_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a0, a3;
    a0 = '0; a0[15:0] = 16'h00D0; a0[DW-1] = 1'b1;
    a3 = '0; a3[15:0] = 16'h00D3;
    l2todr_disp[0 +: DW] = a0;
    l2todr_disp[3*DW +: DW] = a3;
    l2todr_disp_valid = 4'b1001;
    dr_disp_retry = 1'b1;
    #1;
    checks++; if (l2todr_disp_retry !== 4'b1000) begin
      errors++; $display("FAIL bp_first_grant: got %b expected 1000", l2todr_disp_retry); end
    @(posedge clk); #1;
    l2todr_disp_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (dr_disp_valid !== 1'b1 || dr_disp !== a0 || l2todr_disp_retry !== 4'b1000) begin
        errors++; $display("FAIL bp_stall[%0d]: got v=%b d=%h r=%b expected v=1 d=%h r=1000",
                           k, dr_disp_valid, dr_disp[15:0], l2todr_disp_retry, a0[15:0]); end
      @(posedge clk); #1;
    end
    dr_disp_retry = 1'b0;
    #1;
    checks++; if (l2todr_disp_retry !== 4'b0000) begin
      errors++; $display("FAIL bp_release_grant: got %b expected 0000", l2todr_disp_retry); end
    @(posedge clk); #1;
    l2todr_disp_valid = 4'b0000;
    checks++; if (dr_disp_valid !== 1'b1 || dr_disp !== a3) begin
      errors++; $display("FAIL bp_port3: got v=%b d=%h expected v=1 d=%h", dr_disp_valid, dr_disp[15:0], a3[15:0]); end
    @(posedge clk); #1;
    checks++; if (dr_disp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %b expected 0", dr_disp_valid); end
  endtask

  task automatic test_broadcast_snack();
    drtol2_snack_retry = 4'b0010;
    dr_snack = s1;
    dr_snack_valid = 1'b1;
    #1;
    checks++; if (dr_snack_retry !== 1'b0) begin
      errors++; $display("FAIL bc_take: got %b expected 0", dr_snack_retry); end
    @(posedge clk); #1;
    dr_snack = s2;
    #1;
    checks++; if (drtol2_snack_valid !== 4'hf || drtol2_snack[0 +: NW] !== s1 || drtol2_snack[3*NW +: NW] !== s1) begin
      errors++; $display("FAIL bc_cycle1: got v=%b d0=%h expected v=1111 d0=%h", drtol2_snack_valid, drtol2_snack[15:0], s1[15:0]); end
    checks++; if (dr_snack_retry !== 1'b1) begin
      errors++; $display("FAIL bc_retry1: got %b expected 1", dr_snack_retry); end
    for (int k = 2; k <= 3; k++) begin
      @(posedge clk); #2;
      checks++; if (drtol2_snack_valid !== 4'b0010 || dr_snack_retry !== 1'b1) begin
        errors++; $display("FAIL bc_stall[%0d]: got v=%b r=%b expected v=0010 r=1", k, drtol2_snack_valid, dr_snack_retry); end
    end
    @(posedge clk); #1;
    drtol2_snack_retry = 4'b0000;
    #1;
    checks++; if (drtol2_snack_valid !== 4'b0010 || dr_snack_retry !== 1'b0) begin
      errors++; $display("FAIL bc_cycle4: got v=%b r=%b expected v=0010 r=0", drtol2_snack_valid, dr_snack_retry); end
    @(posedge clk); #1;
    dr_snack_valid = 1'b0;
    #1;
    checks++; if (drtol2_snack_valid !== 4'b0100 || drtol2_snack[2*NW +: NW] !== s2) begin
      errors++; $display("FAIL bc_second: got v=%b d=%h expected v=0100 d=%h", drtol2_snack_valid, drtol2_snack[2*NW +: 16], s2[15:0]); end
    @(posedge clk); #1;
    checks++; if (drtol2_snack_valid !== 4'b0000) begin
      errors++; $display("FAIL bc_empty: got %b expected 0000", drtol2_snack_valid); end
  endtask

  task automatic test_dack_during_stall();
    drtol2_snack_retry = 4'b0010;
    dr_snack = s1;
    dr_snack_valid = 1'b1;
    @(posedge clk); #1;
    dr_snack_valid = 1'b0;
    @(posedge clk); #1;
    dr_dack = 16'h1233;
    dr_dack_valid = 1'b1;
    #1;
    checks++; if (dr_dack_retry !== 1'b0 || drtol2_dack_valid !== 4'b0000) begin
      errors++; $display("FAIL dack_take: got r=%b v=%b expected r=0 v=0000", dr_dack_retry, drtol2_dack_valid); end
    @(posedge clk); #1;
    dr_dack_valid = 1'b0;
    #1;
    checks++; if (drtol2_dack_valid !== 4'b1000 || drtol2_dack[3*KW +: KW] !== 16'h1233) begin
      errors++; $display("FAIL dack_route: got v=%b d=%h expected v=1000 d=1233", drtol2_dack_valid, drtol2_dack[3*KW +: KW]); end
    checks++; if (drtol2_snack_valid !== 4'b0010 || dr_snack_retry !== 1'b1) begin
      errors++; $display("FAIL dack_snack_stalled: got v=%b r=%b expected v=0010 r=1", drtol2_snack_valid, dr_snack_retry); end
    @(posedge clk); #1;
    checks++; if (drtol2_dack_valid !== 4'b0000) begin
      errors++; $display("FAIL dack_drain: got %b expected 0000", drtol2_dack_valid); end
    drtol2_snack_retry = 4'b0000;
    @(posedge clk); #1;
    checks++; if (drtol2_snack_valid !== 4'b0000) begin
      errors++; $display("FAIL dack_snack_drain: got %b expected 0000", drtol2_snack_valid); end
  endtask

  task automatic test_reset_mid();
    dr_req_retry = 1'b1;
    l2todr_req[0 +: RW] = 64'h40;
    l2todr_req[1*RW +: RW] = 64'h77;
    l2todr_req_valid = 4'b0010;
    drtol2_snack_retry = 4'b0010;
    dr_snack = s1;
    dr_snack_valid = 1'b1;
    @(posedge clk); #1;
    l2todr_req_valid = 4'b0000;
    dr_snack_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (dr_req_valid !== 1'b1 || drtol2_snack_valid !== 4'b0010) begin
      errors++; $display("FAIL mid_precond: got req_v=%b snack_v=%b expected 1 0010", dr_req_valid, drtol2_snack_valid); end
    reset = 1'b1;
    l2todr_req_valid = 4'hf;
    #1;
    checks++; if (l2todr_req_retry !== 4'hf) begin
      errors++; $display("FAIL mid_reset_retry: got %b expected 1111", l2todr_req_retry); end
    @(posedge clk); #1;
    reset = 1'b0;
    dr_req_retry = 1'b0;
    drtol2_snack_retry = 4'b0000;
    checks++; if (dr_req_valid !== 1'b0 || drtol2_snack_valid !== 4'b0000) begin
      errors++; $display("FAIL mid_valids: got req_v=%b snack_v=%b expected 0 0000", dr_req_valid, drtol2_snack_valid); end
    #1;
    checks++; if (l2todr_req_retry !== 4'b1110) begin
      errors++; $display("FAIL mid_first_grant: got %b expected 1110", l2todr_req_retry); end
    @(posedge clk); #1;
    l2todr_req_valid = 4'h0;
    checks++; if (dr_req_valid !== 1'b1 || dr_req !== 64'h40) begin
      errors++; $display("FAIL mid_port0: got v=%b d=%h expected v=1 d=40", dr_req_valid, dr_req); end
  endtask

  initial begin
    s1 = '0; s1[NW-1] = 1'b1; s1[15:0] = 16'hB1C1;
    s2 = '0; s2[15:0] = 16'h0C02;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_broadcast_snack();
    test_dack_during_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
